// File: rtl/vga_vblank_arbiter.sv
// Purpose: round-robin arbiter that lets N update engines own the shared game-state/pixel resource during VGA vertical blanking only.
// Latency: a request is granted one cycle after the arbiter enters ARB; a release/timeout drops gnt on the next edge, leaving one idle ARB cycle between grants.
// Backpressure: a requester holds req high until it is granted; each requester gets at most one grant per frame; grants are revoked on timeout or at the guard point before active video.
//
// Ports:
//   pixel_clk, reset         : pixel clock; asynchronous active-high reset
//   h_count, v_count         : sync generator counters
//   req, done                : level request and one-cycle release pulse per engine
//   gnt, grant_id, busy      : registered one-hot grant, its index (0 when idle), any grant active
//   frame_tick, timeout, preempt : one-cycle event pulses
module vga_vblank_arbiter #(
  parameter int N_REQ     = 4,
  parameter int H_TOTAL   = 800,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525,
  parameter int MAX_GRANT = 2048,
  parameter int GUARD     = 16
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       grant_id,
  output logic             busy,
  output logic             frame_tick,
  output logic             timeout,
  output logic             preempt
);

  localparam int CW = $clog2(MAX_GRANT + 1);

  localparam logic [1:0] S_DISPLAY = 2'd0;
  localparam logic [1:0] S_ARB     = 2'd1;
  localparam logic [1:0] S_GRANTED = 2'd2;
  localparam logic [1:0] S_CLOSED  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [2:0]       rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       id_q, id_d;
  logic             frame_tick_q, frame_tick_d;
  logic             timeout_q, timeout_d;
  logic             preempt_q, preempt_d;

  logic             open_evt, close_evt;
  logic [N_REQ-1:0] elig;
  logic             pick_vld;
  logic [2:0]       pick_idx;
  logic             release_req;

  assign open_evt  = (v_count == 10'(V_ACTIVE)) && (h_count == 10'd0);
  assign close_evt = (v_count == 10'(V_TOTAL - 1)) && (h_count >= 10'(H_TOTAL - GUARD));

  assign elig = req & ~served_q;

  // Round-robin pick: the lowest eligible index above the pointer wins;
  // only if there is none does the search wrap to the lowest index at or
  // below the pointer. Descending loops let the lowest index overwrite last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (3'(i) <= rr_q)) begin
        pick_vld = 1'b1;
        pick_idx = 3'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (3'(i) > rr_q)) begin
        pick_vld = 1'b1;
        pick_idx = 3'(i);
      end
    end
  end

  // Masking with the one-hot grant selects done/req of the owner and
  // ignores pulses from anyone else.
  assign release_req = (|(done & gnt_q)) || !(|(req & gnt_q));

  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    id_d         = id_q;
    frame_tick_d = 1'b0;
    timeout_d    = 1'b0;
    preempt_d    = 1'b0;

    case (state_q)
      S_DISPLAY: begin
        gnt_d = '0;
        id_d  = 3'd0;
        if (open_evt) begin
          frame_tick_d = 1'b1;
          served_d     = '0;
          state_d      = S_ARB;
        end
      end

      S_ARB: begin
        if (close_evt) begin
          state_d = S_CLOSED;
        end else if (pick_vld) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          id_d    = pick_idx;
          cnt_d   = '0;
          state_d = S_GRANTED;
        end
      end

      S_GRANTED: begin
        cnt_d = cnt_q + CW'(1);
        if (close_evt || release_req || (cnt_q == CW'(MAX_GRANT - 1))) begin
          served_d = served_q | gnt_q;
          rr_d     = id_q;
          gnt_d    = '0;
          id_d     = 3'd0;
          cnt_d    = '0;
          if (close_evt) begin
            preempt_d = 1'b1;
            state_d   = S_CLOSED;
          end else begin
            timeout_d = !release_req;
            state_d   = S_ARB;
          end
        end
      end

      default: begin
        gnt_d = '0;
        id_d  = 3'd0;
        if (v_count < 10'(V_ACTIVE)) state_d = S_DISPLAY;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_DISPLAY;
      served_q     <= '0;
      rr_q         <= 3'(N_REQ - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      id_q         <= 3'd0;
      frame_tick_q <= 1'b0;
      timeout_q    <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      served_q     <= served_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      id_q         <= id_d;
      frame_tick_q <= frame_tick_d;
      timeout_q    <= timeout_d;
      preempt_q    <= preempt_d;
    end
  end

  assign gnt        = gnt_q;
  assign grant_id   = id_q;
  assign busy       = |gnt_q;
  assign frame_tick = frame_tick_q;
  assign timeout    = timeout_q;
  assign preempt    = preempt_q;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Purpose: exercises vga_vblank_arbiter against a frame-level behavioural model of vblank access.
// Latency: outputs are compared 1 ns after every rising edge against the model's post-edge view.
// Backpressure: requests and release pulses come from directed tables and $urandom.
module tb_vga_vblank_arbiter;

  localparam int N    = 4;
  localparam int MAXG = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [9:0]   h_cnt = 10'd0;
  logic [9:0]   v_cnt = 10'd0;
  logic [N-1:0] req_r = '0;
  logic [N-1:0] done_r = '0;
  logic [N-1:0] gnt;
  logic [2:0]   grant_id;
  logic         busy, frame_tick, timeout, preempt;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting for vblank, 1 = access window open, 2 = window shut.
  int       m_phase;
  bit       m_busy;
  bit [1:0] m_owner;
  int       m_held;   // cycles the current grant has been visible
  bit [1:0] m_last;
  bit [N-1:0] m_served;
  bit       exp_ft, exp_to, exp_pe;

  vga_vblank_arbiter #(
    .N_REQ(N), .H_TOTAL(800), .V_ACTIVE(480), .V_TOTAL(525), .MAX_GRANT(MAXG), .GUARD(16)
  ) dut (
    .pixel_clk(clk), .reset(reset), .h_count(h_cnt), .v_count(v_cnt),
    .req(req_r), .done(done_r), .gnt(gnt), .grant_id(grant_id), .busy(busy),
    .frame_tick(frame_tick), .timeout(timeout), .preempt(preempt)
  );

  always #20 clk = ~clk;

  function automatic logic [10:0] obs_vec();
    return {gnt, grant_id, busy, frame_tick, timeout, preempt};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] g;
    logic [2:0] id;
    g  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    id = m_busy ? {1'b0, m_owner} : 3'd0;
    return {g, id, m_busy, exp_ft, exp_to, exp_pe};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_busy = 0; m_owner = 0; m_held = 0; m_last = 2'(N - 1);
    m_served = '0; exp_ft = 0; exp_to = 0; exp_pe = 0;
  endtask

  task automatic m_finish();
    m_served[m_owner] = 1'b1;
    m_last = m_owner;
    m_busy = 0;
  endtask

  // One clock edge of the access rules, evaluated on the pre-edge inputs.
  task automatic m_edge();
    bit closing;
    bit [1:0] cand;
    exp_ft = 0; exp_to = 0; exp_pe = 0;
    closing = (v_cnt == 10'd524) && (h_cnt >= 10'd784);
    if (m_phase == 0) begin
      if (v_cnt == 10'd480 && h_cnt == 10'd0) begin
        m_phase = 1; exp_ft = 1; m_served = '0;
      end
    end else if (m_phase == 1) begin
      if (m_busy) begin
        if (closing) begin
          exp_pe = 1; m_finish(); m_phase = 2;
        end else if (done_r[m_owner] || !req_r[m_owner]) begin
          m_finish();
        end else if (m_held == MAXG) begin
          exp_to = 1; m_finish();
        end else begin
          m_held++;
        end
      end else if (closing) begin
        m_phase = 2;
      end else begin
        for (int k = 1; k <= N; k++) begin
          cand = 2'((int'(m_last) + k) % N);
          if (req_r[cand] && !m_served[cand]) begin
            m_busy = 1; m_owner = cand; m_held = 1;
            break;
          end
        end
      end
    end else begin
      if (v_cnt < 10'd480) m_phase = 0;
    end
  endtask

  // Advance one pixel clock: model sees the pre-edge inputs, then the counters move on.
  task automatic step();
    @(posedge clk);
    if (reset) m_reset(); else m_edge();
    #1;
    if (h_cnt == 10'd799) begin
      h_cnt = 10'd0;
      v_cnt = (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt = h_cnt + 10'd1;
    end
  endtask

  task automatic test_reset();
    int ticks;
    m_reset();
    #1 reset = 1'b1;
    #4;
    checks++;
    if (obs_vec() !== 11'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required %b", obs_vec(), 11'b0);
    end
    #35 reset = 1'b0;
    h_cnt = 10'd0; v_cnt = 10'd0;
    repeat (300) begin
      req_r = 4'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL display_idle: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
    end
    req_r = '0; h_cnt = 10'd790; v_cnt = 10'd479; ticks = 0;
    repeat (40) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL vblank_open: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
      if (frame_tick) begin
        ticks++;
        checks++;
        if (!(v_cnt == 10'd480 && h_cnt == 10'd1)) begin
          errors++; $display("FAIL tick_position: got h=%0d v=%0d required tick after h=0 v=480", h_cnt, v_cnt);
        end
      end
    end
    checks++;
    if (ticks !== 1) begin
      errors++; $display("FAIL tick_count: got %0d required 1", ticks);
    end
  endtask

  // Runs one access window with done pulsed after dhold visible cycles; returns grant order.
  task automatic run_window(input logic [N-1:0] pattern, input int cycles, input int dhold, output int order[$]);
    bit prev_busy = 0;
    order.delete();
    req_r = '0; h_cnt = 10'd700; v_cnt = 10'd524;
    repeat (150) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL frame_close: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
    end
    h_cnt = 10'd795; v_cnt = 10'd479; req_r = pattern;
    repeat (cycles) begin
      done_r = (m_busy && m_held == dhold) ? (4'b0001 << m_owner) : 4'b0000;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL window: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
    end
    done_r = '0;
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[4] = '{0, 1, 2, 3};
    run_window(4'b1111, 80, 10, order);
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL rr_grant_count: got %0d required 4", order.size());
    end else begin
      foreach (want[i]) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, order[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_rr_pointer();
    int order[$];
    run_window(4'b0110, 60, 10, order);
    checks++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 2) begin
      errors++; $display("FAIL rr_pointer_order: got %p required 1,2", order);
    end
  endtask

  task automatic test_timeout();
    int hold2 = 0, to_cnt = 0, n = 0;
    int order[$];
    bit prev_busy = 0;
    run_window(4'b0000, 1, 0, order);
    h_cnt = 10'd795; v_cnt = 10'd479; req_r = 4'b0100;
    order.delete();
    repeat (130) begin
      if (n == 20) req_r[3] = 1'b1;
      done_r = (m_busy && m_owner == 2'd3 && m_held == 5) ? 4'b1000 : 4'b0000;
      step();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_cycle: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
      if (gnt[2]) hold2++;
      if (timeout) to_cnt++;
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
    end
    done_r = '0;
    checks++;
    if (hold2 != MAXG) begin
      errors++; $display("FAIL timeout_hold: got %0d cycles required %0d", hold2, MAXG);
    end
    checks++;
    if (to_cnt != 1) begin
      errors++; $display("FAIL timeout_pulses: got %0d required 1", to_cnt);
    end
    checks++;
    if (order.size() != 2 || order[0] != 2 || order[1] != 3) begin
      errors++; $display("FAIL timeout_next: got %p required 2,3", order);
    end
  endtask

  task automatic test_preempt();
    int held = 0, late = 0;
    bit seen_pe = 0;
    req_r = '0; h_cnt = 10'd695; v_cnt = 10'd524;
    repeat (405) begin
      if (h_cnt == 10'd699 && v_cnt == 10'd524) req_r = 4'b0001;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL preempt_cycle: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
      if (gnt[0]) held++;
      if (seen_pe && busy) late++;
      if (preempt) begin
        seen_pe = 1;
        checks++;
        if (!(h_cnt == 10'd785 && v_cnt == 10'd524)) begin
          errors++; $display("FAIL preempt_position: got h=%0d v=%0d required revoke at h=784 v=524", h_cnt, v_cnt);
        end
      end
    end
    checks++;
    if (held != 85 || !seen_pe) begin
      errors++; $display("FAIL preempt_hold: got %0d cycles preempt=%0d required 85 cycles preempt=1", held, seen_pe);
    end
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL grant_in_active: got %0d busy cycles required 0", late);
    end
  endtask

  task automatic test_async_reset();
    int order[$];
    bit prev_busy = 0;
    h_cnt = 10'd795; v_cnt = 10'd479; req_r = 4'b1000;
    repeat (20) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL pre_reset: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL pre_reset_grant: got %b required %b", gnt, 4'b1000);
    end
    #12 reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (obs_vec() !== 11'b0) begin
      errors++; $display("FAIL async_drop: got %b required %b", obs_vec(), 11'b0);
    end
    #40 reset = 1'b0;
    req_r = 4'b1111; h_cnt = 10'd795; v_cnt = 10'd479;
    repeat (30) begin
      done_r = (m_busy && m_held == 5) ? (4'b0001 << m_owner) : 4'b0000;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL post_reset: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
      end
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
    end
    done_r = '0;
    checks++;
    if (order.size() == 0 || order[0] != 0) begin
      errors++; $display("FAIL post_reset_first: got %p required first grant 0", order);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      h_cnt = 10'd790; v_cnt = 10'd479; req_r = 4'($urandom);
      repeat (500) begin
        if ($urandom_range(0, 30) == 0) req_r = 4'($urandom);
        done_r = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
        step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_window: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
        end
      end
      h_cnt = 10'd700; v_cnt = 10'd524;
      repeat (150) begin
        if ($urandom_range(0, 30) == 0) req_r = 4'($urandom);
        done_r = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
        step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_close: h=%0d v=%0d got %b required %b", h_cnt, v_cnt, obs_vec(), exp_vec());
        end
      end
    end
    done_r = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rr_pointer();
    test_timeout();
    test_preempt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_vblank_arbiter.md
Name: vga_vblank_arbiter

Overview:
- Schedules exclusive access to the shared game-state/pixel resource between N update engines (game logic, sprite mover, score updater, ...).
- Access is granted only inside the vertical blanking window of the 640x480 VGA timing; during active video the display pipeline owns the resource.
- Sits beside VGA_Top, runs on pixel_clk (25 MHz), and consumes the sync generator's h/v counters.
- Round-robin arbitration, at most one grant per requester per frame, with per-grant timeout and forced preemption before active video resumes.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- H_TOTAL, 800, pixels per line incl. blanking
- V_ACTIVE, 480, visible lines; vblank starts at v_count == V_ACTIVE
- V_TOTAL, 525, lines per frame
- MAX_GRANT, 2048, max cycles a single grant may be held
- GUARD, 16, cycles before frame end at which all grants are revoked

Ports:
- pixel_clk  in  1  pixel clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- h_count  in  10  horizontal counter from sync generator (0..H_TOTAL-1)
- v_count  in  10  vertical counter from sync generator (0..V_TOTAL-1)
- req  in  N_REQ  level request per engine
- done  in  N_REQ  one-cycle release pulse from the granted engine
- gnt  out  N_REQ  one-hot grant, registered
- grant_id  out  3  index of current grant; 0 when idle
- busy  out  1  any grant active
- frame_tick  out  1  one-cycle pulse at vblank start
- timeout  out  1  one-cycle pulse when a grant hits MAX_GRANT
- preempt  out  1  one-cycle pulse when a grant is revoked at the guard point

Behaviour:
- Reset: all outputs 0; state DISPLAY; served mask 0; rr pointer = N_REQ-1, so req[0] has first priority; grant counter 0.
- open_evt = (v_count == V_ACTIVE && h_count == 0).
- close_evt = (v_count == V_TOTAL-1 && h_count >= H_TOTAL-GUARD).
- States:
  - DISPLAY: gnt = 0. On open_evt, pulse frame_tick in the same registered cycle, clear the served mask, go to ARB.
  - ARB:
    - close_evt -> CLOSED.
    - Otherwise search for the first index after the rr pointer (wrapping modulo N_REQ) with req = 1 and served = 0. If found, register gnt one-hot and grant_id, clear the counter, go to GRANTED. Latency is req to gnt = 1 cycle from ARB entry.
    - With no eligible requester, remain in ARB.
  - GRANTED: the counter increments each cycle. Exit conditions are checked in priority order:
    1. close_evt: revoke, preempt = 1, go to CLOSED.
    2. done[id] or req[id] = 0: release.
    3. counter == MAX_GRANT-1: revoke, timeout = 1.
    - Every exit marks the requester served and sets rr pointer = id. Releases (2) and timeouts (3) return to ARB; gnt drops in the next cycle.
  - CLOSED: gnt = 0. When v_count < V_ACTIVE (new frame), go to DISPLAY.
- Arbitration details:
  - done pulses on non-granted indices are ignored.
  - A request asserted after its owner was served waits for the next frame.
  - Gaps: one idle cycle minimum between consecutive grants (ARB cycle). No two gnt bits are ever high together.
- busy = |gnt; grant_id is held 0 whenever gnt = 0.
- Asynchronous reset during GRANTED drops gnt immediately, without waiting for the clock. No timeout or preempt pulse is generated.
- If counters jump (sync generator reset) while in ARB/GRANTED, the close_evt/open_evt rules still apply. Without close_evt, the grant persists until done or timeout.

Test Plan:
- Reset held 40 ns, then counters free-run from 0,0 → gnt = 0 through the active frame; frame_tick pulses exactly once at v=480, h=0.
- req = 4'b1111, each engine pulses done 10 cycles after its grant → grants in order 0,1,2,3, each 1 idle cycle apart; no second grant in the same frame.
- Continuing the previous case, next frame with req = 4'b0110 → grant order 1 then 2, each once per frame. The rr pointer only sets the starting index, so order is always ascending from pointer+1 with wrap.
- MAX_GRANT = 100, req[2] held, never done → gnt[2] high for exactly 100 cycles; timeout pulses once; req[3] is granted next.
- req[0] granted at v=524, h=700, never done → revoked at h=784 with preempt = 1; gnt = 0 through the following active frame.
- Async reset asserted mid-grant (#13 ns offset from clock edge) → gnt = 0 immediately; after release, the first grant goes to req[0] at the next vblank.
